cordic_iter_sincos: RTL and testbench

CORDIC_ITER_SINCOS -- requirements
Module: cordic_iter_sincos

---
 rtl/cordic_iter_sincos_if.sv | 24 ++
 rtl/cordic_iter_sincos.sv | 207 ++++++++++++++++++++
 tb/tb_cordic_iter_sincos.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_iter_sincos_if.sv
// Angle-in / sin-cos-out handshake bundle for the iterative CORDIC block.
interface cordic_iter_sincos_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    radian_en;
  logic signed [WIDTH-1:0] angle;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] sin;
  logic signed [WIDTH-1:0] cos;
  logic                    err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output radian_en, angle, in_valid, out_ready,
    input  in_ready, sin, cos, err, out_valid
  );

  modport slave (
    input  radian_en, angle, in_valid, out_ready,
    output in_ready, sin, cos, err, out_valid
  );
endinterface

// File: rtl/cordic_iter_sincos.sv
// Iterative rotation-mode CORDIC: one angle in (degrees or radians), sin/cos out.
// One micro-rotation per clock; quadrant folding keeps z inside +/-pi/2.
module cordic_iter_sincos #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITERS = 14
) (
  input logic                  clk,
  input logic                  rst,
  cordic_iter_sincos_if.slave  bus
);

  localparam int unsigned XW = WIDTH + 2;  // x/y with two headroom bits
  localparam int unsigned ZW = WIDTH + 1;  // z holds up to ~pi before folding
  localparam int unsigned IW = $clog2(ITERS + 1);

  localparam real PiR = 3.14159265358979323846;

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    for (int k = 0; k < n; k++) r = r * 2.0;
    return r;
  endfunction

  // Taylor series is enough for t <= 0.5; t = 1 is the one exact special case.
  function automatic real atan_r(input real t);
    real acc;
    real p;
    if (t >= 1.0) return PiR / 4.0;
    acc = 0.0;
    p   = t;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) acc = acc + p / real'(2 * k + 1);
      else            acc = acc - p / real'(2 * k + 1);
      p = p * t * t;
    end
    return acc;
  endfunction

  localparam int unsigned PiQ     = $rtoi(PiR * pow2(WIDTH - 3) + 0.5);
  localparam int unsigned HalfPiQ = $rtoi(PiR / 2.0 * pow2(WIDTH - 3) + 0.5);
  localparam int unsigned DegK    = $rtoi(PiR / 180.0 * pow2(WIDTH - 3) + 0.5);
  localparam int unsigned XInit   = $rtoi(0.6072529350 * pow2(WIDTH - 2) + 0.5);

  localparam logic signed [WIDTH-1:0] PiS     = WIDTH'(PiQ);
  localparam logic signed [WIDTH-1:0] DegMaxS = WIDTH'(180);
  localparam logic signed [ZW-1:0]    PiZ     = ZW'(PiQ);
  localparam logic signed [ZW-1:0]    HalfZ   = ZW'(HalfPiQ);
  localparam logic signed [ZW-1:0]    DegKZ   = ZW'(DegK);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPrep = 2'd1;
  localparam logic [1:0] StRot  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Elaboration-time arctangent table, Q3.(WIDTH-3)
  logic signed [ZW-1:0] atan_tab [ITERS];
  for (genvar g = 0; g < ITERS; g++) begin : g_atan
    localparam int unsigned Entry = $rtoi(atan_r(1.0 / pow2(g)) * pow2(WIDTH - 3) + 0.5);
    assign atan_tab[g] = ZW'(Entry);
  end

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v > $signed({3'b000, {(WIDTH-1){1'b1}}})) return {1'b0, {(WIDTH-1){1'b1}}};
    if (v < $signed({3'b111, {(WIDTH-1){1'b0}}})) return {1'b1, {(WIDTH-1){1'b0}}};
    return v[WIDTH-1:0];
  endfunction

  logic [1:0]              state_q, state_d;
  logic signed [WIDTH-1:0] angle_q, angle_d;
  logic                    rad_q, rad_d;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]    z_q, z_d;
  logic [IW-1:0]           i_q, i_d;
  logic                    neg_q, neg_d;
  logic signed [WIDTH-1:0] sin_q, sin_d, cos_q, cos_d;
  logic                    err_q, err_d;
  logic                    valid_q, valid_d;

  logic signed [ZW-1:0] angle_ext, z_raw, z_fold;
  logic                 range_err, fold;
  logic signed [XW-1:0] x_n, y_n, x_sh, y_sh;
  logic signed [ZW-1:0] z_n;
  logic                 d_pos;

  // Angle conversion, range check and quadrant fold for the PREP cycle
  always_comb begin
    angle_ext = {angle_q[WIDTH-1], angle_q};
    z_raw     = rad_q ? angle_ext : angle_ext * DegKZ;
    if (rad_q) range_err = (angle_q > PiS) || (angle_q < -PiS);
    else       range_err = (angle_q > DegMaxS) || (angle_q < -DegMaxS);
    fold   = (z_raw > HalfZ) || (z_raw < -HalfZ);
    z_fold = z_raw;
    if (z_raw > HalfZ)       z_fold = z_raw - PiZ;
    else if (z_raw < -HalfZ) z_fold = z_raw + PiZ;
  end

  // One micro-rotation; direction follows the sign of the residual angle
  always_comb begin
    d_pos = ~z_q[ZW-1];
    x_sh  = x_q >>> i_q;
    y_sh  = y_q >>> i_q;
    x_n   = d_pos ? x_q - y_sh : x_q + y_sh;
    y_n   = d_pos ? y_q + x_sh : y_q - x_sh;
    z_n   = d_pos ? z_q - atan_tab[i_q] : z_q + atan_tab[i_q];
  end

  // Next-state and datapath sequencing
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    rad_d   = rad_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    neg_d   = neg_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    err_d   = err_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          angle_d = bus.angle;
          rad_d   = bus.radian_en;
          state_d = StPrep;
        end
      end
      StPrep: begin
        if (range_err) begin
          err_d   = 1'b1;
          sin_d   = '0;
          cos_d   = '0;
          state_d = StDone;
        end else begin
          err_d   = 1'b0;
          z_d     = z_fold;
          neg_d   = fold;
          x_d     = XW'(XInit);
          y_d     = '0;
          i_d     = '0;
          state_d = StRot;
        end
      end
      StRot: begin
        x_d = x_n;
        y_d = y_n;
        z_d = z_n;
        i_d = i_q + IW'(1);
        if (i_q == IW'(ITERS - 1)) begin
          sin_d   = sat(neg_q ? -y_n : y_n);
          cos_d   = sat(neg_q ? -x_n : x_n);
          state_d = StDone;
        end
      end
      StDone: begin
        // out_valid rises one edge after DONE is entered, then waits for the consumer
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      angle_q <= '0;
      rad_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      neg_q   <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      rad_q   <= rad_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      neg_q   <= neg_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.sin       = sin_q;
  assign bus.cos       = cos_q;
  assign bus.err       = err_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_cordic_iter_sincos.sv
// Directed bench for cordic_iter_sincos: ideal-trig model plus hand-computed pins.
module tb_cordic_iter_sincos;

  localparam int W   = 16;
  localparam int N   = 14;
  localparam int TOL = 8;  // table rounding plus shift truncation
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cordic_iter_sincos_if #(.WIDTH(W)) bus ();

  cordic_iter_sincos #(.WIDTH(W), .ITERS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int s;
    int c;
    bit e;
    int lat;
    int cap;
  } exp_t;

  typedef struct {
    int a;
    bit r;
    bit pin;
    bit e;
    int s;
    int c;
  } vec_t;

  exp_t q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   first    = 1'b1;
  int   last_s   = 0;
  int   last_c   = 0;
  bit   last_e   = 1'b0;

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  // Expected result straight from the arithmetic definition of the conversion
  function automatic exp_t model(int a, bit r);
    exp_t m;
    int   z;
    int   kdeg;
    int   piq;
    real  zr;
    kdeg  = rnd(PI / 180.0 * 8192.0);
    piq   = rnd(PI * 8192.0);
    m.cap = 0;
    m.lat = N + 2;
    if (r) begin
      m.e = (a > piq) || (a < -piq);
      z   = a;
    end else begin
      m.e = (a > 180) || (a < -180);
      z   = a * kdeg;
    end
    if (m.e) begin
      m.s   = 0;
      m.c   = 0;
      m.lat = 2;
    end else begin
      zr  = real'(z) / 8192.0;
      m.s = rnd($sin(zr) * 16384.0);
      m.c = rnd($cos(zr) * 16384.0);
    end
    return m;
  endfunction

  task automatic chk_eq(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic chk_near(input string nm, input int act, input int expv, input int tol);
    n_checks++;
    if (act - expv > tol || expv - act > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, expv, tol);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: record accepted requests, check every cycle out_valid is high
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.in_valid && bus.in_ready) begin
          m     = model(int'($signed(bus.angle)), bus.radian_en);
          m.cap = cyc + 1;
          q.push_back(m);
        end
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            chk_eq("unexpected out_valid", int'(bus.out_valid), 0);
          end else begin
            chk_eq("in_ready while out_valid", int'(bus.in_ready), 0);
            chk_eq("err", int'(bus.err), int'(q[0].e));
            chk_near("sin", int'(bus.sin), q[0].s, q[0].e ? 0 : TOL);
            chk_near("cos", int'(bus.cos), q[0].c, q[0].e ? 0 : TOL);
            if (first) chk_eq("latency", cyc - q[0].cap, q[0].lat);
            first = 1'b0;
            if (bus.out_ready) begin
              last_s = int'(bus.sin);
              last_c = int'(bus.cos);
              last_e = bus.err;
              void'(q.pop_front());
              first = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic send(input int a, input bit r);
    bit ok;
    ok = 1'b0;
    bus.angle     = 16'(a);
    bus.radian_en = r;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) chk_eq("accept timeout", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    // Scramble inputs after capture; the block must ignore them
    bus.in_valid  = 1'b0;
    bus.angle     = 16'h7fff;
    bus.radian_en = ~r;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      done = (q.size() == 0) && bus.in_ready;
    end
    if (!done) chk_eq("completion timeout", q.size(), 0);
  endtask

  task automatic add(input int a, input bit r, input bit pin, input bit e, input int s,
                     input int c);
    vec_t v;
    v.a = a; v.r = r; v.pin = pin; v.e = e; v.s = s; v.c = c;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t m;
    int   hs;
    int   hc;
    int   he;
    bit   seen;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    int   hs;
    int   hc;
    int   he;
    bit   seen;

    bus.in_valid  = 1'b0;
    bus.angle     = '0;
    bus.radian_en = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk_eq("reset in_ready", int'(bus.in_ready), 1);
    chk_eq("reset out_valid", int'(bus.out_valid), 0);
    chk_eq("reset sin", int'(bus.sin), 0);
    chk_eq("reset cos", int'(bus.cos), 0);
    chk_eq("reset err", int'(bus.err), 0);

    // Pin the model against hand-derived values
    m = model(30, 1'b0);
    chk_near("model sin 30deg", m.s, 8193, 1);
    chk_near("model cos 30deg", m.c, 14188, 1);
    m = model(4289, 1'b1);
    chk_near("model sin pi/6", m.s, 8191, 1);
    chk_near("model cos pi/6", m.c, 14189, 1);
    m = model(181, 1'b0);
    chk_eq("model err 181deg", int'(m.e), 1);
    chk_eq("model err latency", m.lat, 2);
    m = model(-150, 1'b0);
    chk_near("model sin -150deg", m.s, -8186, 1);
    chk_eq("model latency", m.lat, 16);

    // Release reset just after an edge; the very next edge must capture
    #5;
    rst = 1'b1;
    send(30, 1'b0);
    wait_idle();
    chk_near("first 30deg sin", last_s, 8193, TOL);
    chk_near("first 30deg cos", last_c, 14188, TOL);

    add(4289, 1'b1, 1'b1, 1'b0, 8191, 14189);
    add(0, 1'b1, 1'b1, 1'b0, 0, 16384);
    add(-150, 1'b0, 1'b1, 1'b0, -8186, -14192);
    add(90, 1'b0, 1'b1, 1'b0, 16384, -4);
    add(180, 1'b0, 1'b1, 1'b0, -8, -16384);
    add(181, 1'b0, 1'b1, 1'b1, 0, 0);
    add(-180, 1'b0, 1'b0, 1'b0, 0, 0);
    add(-181, 1'b0, 1'b1, 1'b1, 0, 0);
    add(25737, 1'b1, 1'b1, 1'b1, 0, 0);
    add(-25736, 1'b1, 1'b0, 1'b0, 0, 0);
    add(45, 1'b0, 1'b0, 1'b0, 0, 0);
    add(120, 1'b0, 1'b0, 1'b0, 0, 0);
    add(-6434, 1'b1, 1'b0, 1'b0, 0, 0);
    add(32767, 1'b0, 1'b0, 1'b0, 0, 0);
    add(-32768, 1'b1, 1'b0, 1'b0, 0, 0);

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      send(vecs[k].a, vecs[k].r);
      wait_idle();
      if (vecs[k].pin) begin
        chk_eq($sformatf("pin err a=%0d", vecs[k].a), int'(last_e), int'(vecs[k].e));
        chk_near($sformatf("pin sin a=%0d", vecs[k].a), last_s, vecs[k].s,
                 vecs[k].e ? 0 : TOL);
        chk_near($sformatf("pin cos a=%0d", vecs[k].a), last_c, vecs[k].c,
                 vecs[k].e ? 0 : TOL);
      end
    end

    // Backpressure: hold DONE for 10 cycles with a new request pending
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(45, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    chk_eq("backpressure out_valid", int'(bus.out_valid), 1);
    hs = int'(bus.sin);
    hc = int'(bus.cos);
    he = int'(bus.err);
    bus.angle     = -16'sd90;
    bus.radian_en = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk_eq("hold sin", int'(bus.sin), hs);
      chk_eq("hold cos", int'(bus.cos), hc);
      chk_eq("hold err", int'(bus.err), he);
      chk_eq("hold out_valid", int'(bus.out_valid), 1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_eq("idle after release in_ready", int'(bus.in_ready), 1);
    chk_eq("idle after release out_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_idle();
    chk_near("back-to-back -90deg sin", last_s, -16384, TOL);

    // Reset during the rotation phase aborts the request
    @(posedge clk);
    #1;
    send(60, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    first = 1'b1;
    chk_eq("abort out_valid", int'(bus.out_valid), 0);
    chk_eq("abort sin", int'(bus.sin), 0);
    chk_eq("abort cos", int'(bus.cos), 0);
    chk_eq("abort err", int'(bus.err), 0);
    chk_eq("abort in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    send(30, 1'b0);
    wait_idle();
    chk_near("post-abort 30deg sin", last_s, 8193, TOL);
    chk_near("post-abort 30deg cos", last_c, 14188, TOL);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
